// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared constants, types and helpers for the
// parametrised serial-pattern detector (seq_detector_param).
`timescale 1ns/1ps

package seq_detector_pkg;

    // Legacy fixed-detector configuration reproduced at reset.
    localparam logic [15:0] DEFAULT_PATTERN_10010 = 16'b10010;
    localparam int unsigned DEFAULT_LEN_10010     = 5;

    // Effective control state, derived from fill/armed.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } ctrl_state_t;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// seq_window_cmp: combinational compare of the low len bits of the
// sample window against the active pattern; bits at or above len are
// ignored.
`timescale 1ns/1ps

module seq_window_cmp
    import seq_detector_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    // Masked equality: any differing bit below len clears hit.
    always_comb begin
        hit = 1'b1;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) && (window[i] != pat[i])) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy serial-pattern detector with a runtime
// loadable pattern (2..MAX_LEN bits) and overlapping/non-overlapping
// matching. Reset configuration matches the legacy "10010" detector.
// Optional saturating match counter: define SEQ_DETECTOR_MATCH_CNT_EN.
`timescale 1ns/1ps

module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int unsigned          MAX_LEN         = 16,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(DEFAULT_PATTERN_10010),
    parameter int unsigned          DEFAULT_LEN     = DEFAULT_LEN_10010,
    parameter int unsigned          CNT_W           = 8,
    localparam int unsigned         LEN_W           = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               j_valid,
    input  logic               j,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               w,
    output logic               armed
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    if (MAX_LEN < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("seq_detector_param: MAX_LEN must be >= 2 and CNT_W >= 1");
    end

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] window;
    logic               ovl;
    logic               hit;
    logic               armed_next;
    ctrl_state_t        state;

    assign window = {hist, j};

    seq_window_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window (window),
        .pat    (pat),
        .len    (len),
        .hit    (hit)
    );

    // Mealy match flag: a load in the same cycle discards the bit.
    always_comb begin
        w = j_valid & armed & ~cfg_load & hit;
    end

    // Fill count advance and the armed flag it implies for the next cycle.
    always_comb begin
        fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
        if (w && !ovl) begin
            fill_next = '0;
        end
        armed_next = (fill_next >= len - 1'b1);
    end

    // Clamp the requested length into 2..MAX_LEN.
    always_comb begin
        if (cfg_len < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = cfg_len;
        end
    end

    // Configuration, history and fill state; load outranks data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= DEFAULT_PATTERN;
            len   <= LEN_W'(DEFAULT_LEN);
            ovl   <= 1'b1;
            armed <= 1'b0;
        end else if (cfg_load) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= cfg_pattern;
            len   <= len_clamped;
            ovl   <= cfg_overlap;
            armed <= 1'b0;
        end else if (j_valid) begin
            hist  <= window[MAX_LEN-2:0];
            fill  <= fill_next;
            armed <= armed_next;
        end
    end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    // Saturating match counter; clear wins over a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (w && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

    // Control-state view used by the checks below.
    always_comb begin
        state = armed ? ARMED : FILL;
    end

    a_load_disarms: assert property (@(posedge clk) disable iff (rst)
        cfg_load |=> state == FILL);

    a_nonovl_refill: assert property (@(posedge clk) disable iff (rst)
        (w && !ovl) |=> state == FILL);

    a_armed_tracks_fill: assert property (@(posedge clk) disable iff (rst)
        armed == ((32'(fill) + 1) >= 32'(len)));

    c_fill_to_armed: cover property (@(posedge clk) disable iff (rst)
        state == FILL ##1 state == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven directed checks of
// seq_detector_param plus hand-written reset and counter sequences.
// Counter checks are compiled when SEQ_DETECTOR_MATCH_CNT_EN is defined.
`timescale 1ns/1ps

module tb_seq_detector_param;
    import seq_detector_pkg::*;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = len_w(MAX_LEN);
    localparam int unsigned CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               j_valid;
    logic               j;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               w;
    logic               armed;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    logic               cnt_clr;
    logic [CNT_W-1:0]   match_cnt;
`endif

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .j_valid     (j_valid),
        .j           (j),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .w           (w),
        .armed       (armed)
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .match_cnt   (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string              tag;
        logic               ld;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic               v;
        logic               jb;
        logic               ew;
        logic               ea;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_bit(input string tag, input logic v, input logic jb,
                                    input logic ew, input logic ea);
        vec_t r;
        r.tag = tag; r.ld = 1'b0; r.pat = '0; r.len = '0; r.ovl = 1'b0;
        r.v = v; r.jb = jb; r.ew = ew; r.ea = ea;
        vecs.push_back(r);
    endfunction

    function automatic void add_load(input string tag, input logic [MAX_LEN-1:0] p,
                                     input logic [LEN_W-1:0] l, input logic o,
                                     input logic jb, input logic ew, input logic ea);
        vec_t r;
        r.tag = tag; r.ld = 1'b1; r.pat = p; r.len = l; r.ovl = o;
        r.v = 1'b1; r.jb = jb; r.ew = ew; r.ea = ea;
        vecs.push_back(r);
    endfunction

    task automatic drive(input logic ld, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic o, input logic v, input logic jb, input logic clr);
        @(negedge clk);
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        j_valid     = v;
        j           = jb;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        cnt_clr     = clr;
`else
        if (clr) begin end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]         s1;
        logic [MAX_LEN-1:0] p16;

        rst = 1'b1; j_valid = 1'b0; j = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_armed", 32'(armed), 32'd0);
        check("rst_hold_w", 32'(w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_w", 32'(w), 32'd0);
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        check("rst_cnt", 32'(match_cnt), 32'd0);
`endif

        // Reset defaults (10010, overlap): matches on bits 5 and 8.
        s1 = 8'b10010010;
        for (int k = 0; k < 8; k++) begin
            add_bit("t1_default", 1'b1, s1[7-k], (k == 4) || (k == 7), k >= 4);
        end

        // 1111, len 4, non-overlap: match on 4, re-fill, match on 8.
        add_load("t2_load", 16'b1111, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            add_bit("t2_nonovl", 1'b1, 1'b1, (k == 3) || (k == 7), (k == 3) || (k == 7));
        end

        // 1111, len 4, overlap: match on bits 4..7.
        add_load("t3_load", 16'b1111, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            add_bit("t3_ovl", 1'b1, 1'b1, k >= 3, k >= 3);
        end

        // 10010 with invalid gaps; the last gap carries the final bit value.
        add_load("t4_load", 16'b10010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        add_bit("t4_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        add_bit("t4_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            add_bit("t4_gap", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        add_bit("t4_b3", 1'b1, 1'b0, 1'b0, 1'b0);
        add_bit("t4_b4", 1'b1, 1'b1, 1'b0, 1'b0);
        add_bit("t4_gap_armed", 1'b0, 1'b0, 1'b0, 1'b1);
        add_bit("t4_b5", 1'b1, 1'b0, 1'b1, 1'b1);

        // Load coincident with the final bit of 10010.
        add_bit("t5a_b1", 1'b1, 1'b1, 1'b0, 1'b1);
        add_bit("t5a_b2", 1'b1, 1'b0, 1'b0, 1'b1);
        add_bit("t5a_b3", 1'b1, 1'b0, 1'b0, 1'b1);
        add_bit("t5a_b4", 1'b1, 1'b1, 1'b0, 1'b1);
        add_load("t5a_load_last", 16'b10010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        add_bit("t5a_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // cfg_len 1 clamps to 2: pattern 01 over stream 1,1,0,1.
        add_load("t5b_load_len1", 16'b01, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_bit("t5b_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        add_bit("t5b_b2", 1'b1, 1'b1, 1'b0, 1'b1);
        add_bit("t5b_b3", 1'b1, 1'b0, 1'b0, 1'b1);
        add_bit("t5b_b4", 1'b1, 1'b1, 1'b1, 1'b1);

        // cfg_len 20 clamps to 16: full 16-bit pattern, non-overlap.
        p16 = 16'hA5C3;
        add_load("t5c_load_len20", p16, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            add_bit("t5c_bits", 1'b1, p16[15-k], k == 15, k == 15);
        end
        add_bit("t5c_after", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ovl,
                  vecs[i].v, vecs[i].jb, 1'b0);
            #1;
            check($sformatf("%s[%0d].w", vecs[i].tag, i), 32'(w), 32'(vecs[i].ew));
            check($sformatf("%s[%0d].armed", vecs[i].tag, i), 32'(armed), 32'(vecs[i].ea));
        end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        // Counter: saturation, clear-over-match, load keeps count.
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'b1111, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("cnt_cleared", 32'(match_cnt), 32'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        check("cnt_saturated", 32'(match_cnt), 32'd3);
        check("cnt_clr_cycle_w", 32'(w), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("cnt_clr_wins", 32'(match_cnt), 32'd0);
        drive(1'b1, 16'b1111, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("cnt_after_one", 32'(match_cnt), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("cnt_load_keeps", 32'(match_cnt), 32'd1);
`endif

        // Reset mid-pattern: 1,0,0,1 then rst, then 0 must not match.
        drive(1'b1, 16'b10010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_rst_armed", 32'(armed), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_armed", 32'(armed), 32'd0);
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        check("rst_async_cnt", 32'(match_cnt), 32'd0);
`endif
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_w", 32'(w), 32'd0);
        check("post_rst_armed", 32'(armed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector. It replaces the fixed "10010" detector with a runtime-loadable pattern of 2..MAX_LEN bits and selectable overlapping or non-overlapping matching. It sits on a one-bit serial stream qualified by a valid strobe and flags the cycle in which the final pattern bit arrives. Reset defaults reproduce the legacy "10010" overlapping behaviour exactly.

## Interface
- MAX_LEN, 16: maximum pattern length in bits (≥2).
- DEFAULT_PATTERN, 16'b10010: pattern loaded at reset, right-aligned.
- DEFAULT_LEN, 5: pattern length loaded at reset.
- CNT_W, 8: match-counter width (used only with the counter compiled in).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- j_valid  in  1  qualifies j; history advances only when high.
- j  in  1  serial data bit.
- cfg_load  in  1  loads cfg_pattern/cfg_len/cfg_overlap and clears history.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] arrives first, bit 0 arrives last.
- cfg_len  in  LEN_W  pattern length; LEN_W = clog2(MAX_LEN+1).
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- w  out  1  Mealy match flag, combinational from state, j and j_valid.
- armed  out  1  registered; high when fill ≥ len-1.
- cnt_clr  in  1  synchronous clear of match_cnt (counter build only).
- match_cnt  out  CNT_W  saturating match count (counter build only).

## Operation
- Registers:
  - hist[MAX_LEN-2:0]: shift history, newest bit in bit 0.
  - fill: bits seen since last clear, saturating at MAX_LEN-1.
  - pat, len, ovl: active configuration.
- Window = {hist, j}, low len bits.
- w = j_valid & armed & ~cfg_load & (window[len-1:0] == pat[len-1:0]). Bits of pat above len are ignored.
- On j_valid (no cfg_load):
  - hist <= {hist[MAX_LEN-3:0], j}; fill <= min(fill+1, MAX_LEN-1).
  - If w and ovl=0: fill <= 0, so no bit of the matched sequence is reused.
  - If w and ovl=1: fill is kept, so suffix bits can start the next match.
- j_valid low: all state holds; w=0.
- cfg_load:
  - Has priority: the j bit in that cycle is discarded and w=0.
  - Sets pat <= cfg_pattern, ovl <= cfg_overlap, len <= clamp(cfg_len, 2, MAX_LEN), hist <= 0, fill <= 0.
- armed is derived from fill and len. It is 0 after reset and load, and 0 after a non-overlap match until len-1 new bits have arrived.
- Effective control states, from fill and armed: FILL (fill < len-1) → ARMED on the (len-1)th valid bit. ARMED → FILL on a non-overlap match or on cfg_load. ARMED → ARMED otherwise.

## Timing
- Reset values: hist=0, fill=0, pat=DEFAULT_PATTERN, len=DEFAULT_LEN, ovl=1, armed=0, w=0, match_cnt=0.
- Latency: w asserts in the same cycle as the last pattern bit; no pipeline stage.
- New configuration takes effect the cycle after cfg_load.
- Earliest match after reset or load is the len-th valid bit.
- Reset asserted mid-sequence aborts it immediately. No match completes across a reset.
- Within one clock, priority order: rst > cfg_load > j_valid.

## Configuration
- SEQ_DETECTOR_MATCH_CNT_EN defined:
  - cnt_clr and match_cnt exist.
  - match_cnt increments each cycle w=1 and saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; a match in the clear cycle is not counted.
  - cfg_load does not clear the counter.
- SEQ_DETECTOR_MATCH_CNT_EN undefined: both ports and all counter logic are absent; detection behaviour is identical.

## Structure
- Package seq_detector_pkg holds:
  - the LEN_W helper function (clog2(MAX_LEN+1));
  - legacy constants DEFAULT_PATTERN_10010 and DEFAULT_LEN_10010 = 5;
  - the control-state enum {FILL, ARMED}, used for the assertions and coverage.
- One sub-module, seq_window_cmp: a purely combinational masked compare of window against pat under len.

## Test plan
- Reset defaults, stream 1,0,0,1,0,0,1,0 (valid every cycle) → w=1 on bit 5 and bit 8 (overlap).
- Load pattern 0b1111, len=4, overlap=0; stream seven 1s → w=1 on bit 4 only; bits 5–7 re-fill; an eighth 1 gives w=1.
- Same pattern with overlap=1, seven 1s → w=1 on bits 4, 5, 6, 7.
- Stream 1,0,0,1,0 with j_valid low for 3 cycles between bits 2 and 3 → w=1 only when bit 5 is valid; w=0 in all gap cycles.
- cfg_load in the same cycle as the final bit of 10010 → w=0; armed=0 next cycle; cfg_len=1 loads as len=2; cfg_len=20 with MAX_LEN=16 loads as 16.
- Counter build, CNT_W=2: five matches → match_cnt=3 (saturated); cnt_clr in a match cycle → match_cnt=0; rst mid-pattern after 1,0,0,1 followed by 0 → w=0.
